// File: rtl/unary_pkg.sv
// unary_pkg: shared constants, driver state encoding and modulo-add helper for the unary adder driver.
package unary_pkg;
    localparam int CNT_W = 5;
    localparam int CNT_MAX = 16;
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {IDLE, SEND, DRAIN, COLLECT, DONE} drv_state_t;

    function automatic logic [CNT_W-1:0] mod_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        logic [CNT_W:0] w;
        s = {1'b0, a} + {1'b0, b};
        w = s - (CNT_W+1)'(CNT_MAX + 1);
        return (s > {1'b0, MAX_V}) ? w[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/unary_serializer.sv
// unary_serializer: loads a binary count and emits it as a registered run of ones, one per step.
module unary_serializer
    import unary_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] val,
    output logic             q,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (load) begin
            cnt <= val;
            q   <= val != '0;
        end else if (step) begin
            cnt <= cnt - CNT_W'(cnt != '0);
            q   <= cnt > CNT_W'(1);
        end
    end

    // Set while the current cycle carries the final pulse (or there is none).
    assign done = cnt <= CNT_W'(1);
endmodule

// File: rtl/unary_add_driver_1_4_16.sv
// unary_add_driver_1_4_16: serializes two operands into the unary adder and counts the result back.
// Optional UNARY_DRV_CHECK_EN adds res_err, comparing the collected result against a binary reference.
module unary_add_driver_1_4_16
    import unary_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] op_a,
    input  logic [CNT_W-1:0] op_b,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_sum,
    output logic             res_carry
`ifdef UNARY_DRV_CHECK_EN
    ,
    output logic             res_err
`endif
);
    drv_state_t state, nstate;
    logic [CNT_W-1:0] a_sat, b_sat, sum_cnt;
    logic accept, a_done, b_done, carry_acc, skip;

    assign a_sat = (op_a > MAX_V) ? MAX_V : op_a;
    assign b_sat = (op_b > MAX_V) ? MAX_V : op_b;
    assign in_ready = state == IDLE;
    assign accept = in_ready && in_valid;

    unary_serializer ser_a (.clk(clk), .rst_n(rst_n), .load(accept), .step(state == SEND), .val(a_sat), .q(A), .done(a_done));
    unary_serializer ser_b (.clk(clk), .rst_n(rst_n), .load(accept), .step(state == SEND), .val(b_sat), .q(B), .done(b_done));

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = in_valid ? (((a_sat | b_sat) != '0) ? SEND : DRAIN) : IDLE;
            SEND:    nstate = (a_done && b_done) ? DRAIN : SEND;
            DRAIN:   nstate = COLLECT;
            COLLECT: nstate = (!skip && (!dout || sum_cnt == MAX_V)) ? DONE : COLLECT;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Adder-facing outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            carry_acc     <= 1'b0;
            sum_cnt       <= '0;
            skip          <= 1'b0;
            res_valid     <= 1'b0;
            res_sum       <= '0;
            res_carry     <= 1'b0;
        end else begin
            state         <= nstate;
            en            <= nstate == SEND || nstate == COLLECT;
            read_or_write <= nstate == COLLECT;
            skip          <= state == DRAIN;
            res_valid     <= nstate == DONE;
            if (accept) begin
                carry_acc <= 1'b0;
                sum_cnt   <= '0;
            end else begin
                if (state == SEND || state == DRAIN)
                    carry_acc <= carry_acc | C;
                if (state == COLLECT && !skip && dout && sum_cnt != MAX_V)
                    sum_cnt <= sum_cnt + CNT_W'(1);
            end
            if (nstate == DONE) begin
                res_sum   <= sum_cnt;
                res_carry <= carry_acc;
            end
        end
    end

`ifdef UNARY_DRV_CHECK_EN
    logic [CNT_W-1:0] exp_sum;
    logic exp_carry, ovf_seen, ovf_hit;

    assign ovf_hit = state == COLLECT && !skip && dout && sum_cnt == MAX_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sum   <= '0;
            exp_carry <= 1'b0;
            ovf_seen  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            if (accept) begin
                exp_sum   <= mod_add(a_sat, b_sat);
                exp_carry <= ({1'b0, a_sat} + {1'b0, b_sat}) > {1'b0, MAX_V};
                ovf_seen  <= 1'b0;
            end else if (ovf_hit) begin
                ovf_seen <= 1'b1;
            end
            if (nstate == DONE)
                res_err <= (sum_cnt != exp_sum) || (carry_acc != exp_carry) || ovf_seen || ovf_hit;
        end
    end
`endif
endmodule

// File: tb/tb_unary_add_driver_1_4_16.sv
// tb_unary_add_driver_1_4_16: directed bench with a behavioural unary adder attached to the driver.
module tb_unary_add_driver_1_4_16;
    logic clk, rst_n, in_valid, in_ready, A, B, en, read_or_write, dout, C, res_valid, res_carry;
    logic [4:0] op_a, op_b, res_sum;
    int errors = 0;
    int checks = 0;
    int acnt;
    bit kill = 0;
    int send_n, col_n;
    logic [31:0] a_pat, b_pat;
`ifdef UNARY_DRV_CHECK_EN
    logic res_err;
`endif

    unary_add_driver_1_4_16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .A(A), .B(B), .en(en), .read_or_write(read_or_write),
        .dout(dout), .C(C), .res_valid(res_valid), .res_sum(res_sum), .res_carry(res_carry)
`ifdef UNARY_DRV_CHECK_EN
        , .res_err(res_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: read phase accumulates mod 17 and flags wrap; write phase drains one per cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt <= 0;
            C    <= 1'b0;
            dout <= 1'b0;
        end else if (en && !read_or_write) begin
            acnt <= (acnt + int'(A) + int'(B)) % 17;
            if (acnt + int'(A) + int'(B) > 16) C <= 1'b1;
        end else if (en && read_or_write) begin
            C <= 1'b0;
            if (kill && acnt == 1) begin
                dout <= 1'b0;
                acnt <= 0;
            end else begin
                dout <= acnt != 0;
                acnt <= (acnt != 0) ? acnt - 1 : 0;
            end
        end else begin
            dout <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] a, input logic [4:0] b, input bit hold);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        send_n = 0;
        col_n = 0;
        a_pat = '0;
        b_pat = '0;
        n = 0;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        while (!res_valid && n < 200) begin
            if (en && !read_or_write) begin
                send_n++;
                a_pat = (a_pat << 1) | 32'(A);
                b_pat = (b_pat << 1) | 32'(B);
            end
            if (en && read_or_write) col_n++;
            n++;
            @(negedge clk);
        end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_rw", 32'(read_or_write), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'(res_sum), 32'd0);
        chk("rst_carry", 32'(res_carry), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        do_op(5'd3, 5'd4, 1'b0);
        chk("3+4_sum", 32'(res_sum), 32'd7);
        chk("3+4_carry", 32'(res_carry), 32'd0);
        chk("3+4_send", 32'(send_n), 32'd4);
        chk("3+4_apat", a_pat, 32'b1110);
        chk("3+4_bpat", b_pat, 32'b1111);
        chk("3+4_collect", 32'(col_n), 32'd9);

        do_op(5'd16, 5'd16, 1'b0);
        chk("16+16_sum", 32'(res_sum), 32'd15);
        chk("16+16_carry", 32'(res_carry), 32'd1);
        chk("16+16_send", 32'(send_n), 32'd16);
`ifdef UNARY_DRV_CHECK_EN
        chk("16+16_err", 32'(res_err), 32'd0);
`endif

        do_op(5'd0, 5'd0, 1'b0);
        chk("0+0_sum", 32'(res_sum), 32'd0);
        chk("0+0_carry", 32'(res_carry), 32'd0);
        chk("0+0_send", 32'(send_n), 32'd0);
        chk("0+0_collect", 32'(col_n), 32'd2);

        do_op(5'd16, 5'd1, 1'b1);
        chk("16+1_sum", 32'(res_sum), 32'd0);
        chk("16+1_carry", 32'(res_carry), 32'd1);
        chk("16+1_collect", 32'(col_n), 32'd2);
        do_op(5'd5, 5'd0, 1'b0);
        chk("b2b_5+0_sum", 32'(res_sum), 32'd5);
        chk("b2b_5+0_carry", 32'(res_carry), 32'd0);
        chk("b2b_5+0_send", 32'(send_n), 32'd5);
        @(negedge clk);
        chk("valid_pulse_one", 32'(res_valid), 32'd0);
        chk("sum_hold", 32'(res_sum), 32'd5);

        in_valid = 1'b1;
        op_a = 5'd10;
        op_b = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("10+10_send1_en", 32'(en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_A", 32'(A), 32'd0);
        chk("midrst_B", 32'(B), 32'd0);
        chk("midrst_sum", 32'(res_sum), 32'd0);
        chk("midrst_carry", 32'(res_carry), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(5'd2, 5'd2, 1'b0);
        chk("2+2_sum", 32'(res_sum), 32'd4);
        chk("2+2_carry", 32'(res_carry), 32'd0);
        chk("2+2_collect", 32'(col_n), 32'd6);

        do_op(5'd20, 5'd0, 1'b0);
        chk("sat20_sum", 32'(res_sum), 32'd16);
        chk("sat20_send", 32'(send_n), 32'd16);

        kill = 1'b1;
        do_op(5'd6, 5'd6, 1'b0);
        kill = 1'b0;
        chk("short_sum", 32'(res_sum), 32'd11);
        chk("short_collect", 32'(col_n), 32'd13);
`ifdef UNARY_DRV_CHECK_EN
        chk("short_err", 32'(res_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unary_add_driver_1_4_16.md
Name: unary_add_driver_1_4_16

Overview:
- Host-side master for the 1-of-4-of-16 unary adder.
- Accepts two binary operands (0..16) over a valid/ready handshake and serializes them into the unary A/B streams with en and read_or_write=0.
- Then switches the adder to write phase, counts the returned unary dout stream back into a binary sum, and reports sum plus carry.
- Sits between the control plane and the adder; both blocks share clk and rst_n.

Parameters:
- CNT_W, 5, width of operand, sum and internal counters.
- CNT_MAX, 16, maximum unary value; the adder wraps modulo CNT_MAX+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- op_a  input  CNT_W  operand A, binary.
- op_b  input  CNT_W  operand B, binary.
- A  output  1  unary stream A to adder.
- B  output  1  unary stream B to adder.
- en  output  1  adder enable.
- read_or_write  output  1  0 = adder read phase, 1 = adder write phase.
- dout  input  1  unary result stream from adder.
- C  input  1  adder carry flag.
- res_valid  output  1  one-cycle result pulse.
- res_sum  output  CNT_W  binary sum, modulo CNT_MAX+1.
- res_carry  output  1  wrap occurred.

Behaviour:
- Reset values:
  - A, B, en, read_or_write, res_valid, res_sum, res_carry are all 0.
  - State is IDLE, so in_ready = 1.
- All adder-facing outputs are registered.
- FSM states are IDLE, SEND, DRAIN, COLLECT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch op_a/op_b into a_cnt/b_cnt; values above CNT_MAX saturate to CNT_MAX.
  - Clear carry_acc and sum_cnt.
  - Go to SEND if either operand is nonzero, otherwise go to DRAIN.
- SEND:
  - Drive en=1, read_or_write=0, A=(a_cnt!=0), B=(b_cnt!=0).
  - Each cycle, decrement each nonzero counter.
  - Leave for DRAIN in the cycle after the last counter reaches 0.
  - Duration is max(a,b) cycles.
- DRAIN:
  - One cycle with en=0, A=B=0.
  - Captures the carry registered by the final read cycle.
- Carry capture: carry_acc |= C on every edge while in SEND or DRAIN.
  - This is safe because the adder clears C in its write phase and at reset.
- COLLECT:
  - Drive en=1, read_or_write=1.
  - The dout sample at the first COLLECT edge is stale and is ignored.
  - At each later edge: dout=1 increments sum_cnt; dout=0 ends the phase, and the FSM goes to DONE with en deasserted.
  - Total COLLECT cycles = sum+2.
  - If sum_cnt would exceed CNT_MAX, force exit to DONE and saturate the sum.
- DONE:
  - Load res_sum=sum_cnt and res_carry=carry_acc.
  - Pulse res_valid for one cycle, then return to IDLE.
  - res_sum and res_carry hold until the next DONE.
- Back-to-back: with in_valid held, a new request is accepted in the IDLE cycle that follows DONE.
- Reset mid-operation: return immediately to IDLE with all outputs 0. The adder shares rst_n, so its count is also cleared.
- Leaving COLLECT always leaves the adder count at 0, which is the precondition for the next operation.

Optional Feature:
- Macro: UNARY_DRV_CHECK_EN.
- When defined:
  - Add output res_err (1 bit, reset 0).
  - Latch the expected values (a+b) mod (CNT_MAX+1) and a+b > CNT_MAX at accept.
  - In DONE, res_err = 1 if res_sum or res_carry mismatches the expected values, or if the COLLECT overflow exit fired.
  - res_err is valid with res_valid and holds like res_sum.
- When undefined: no port and no compare logic.

Decomposition:
- Package unary_pkg:
  - CNT_W and CNT_MAX constants.
  - Driver state enum typedef.
  - A modulo-add helper function used by the check feature.
- Sub-module unary_serializer:
  - Load, binary down-counter, bit output and done flag.
  - Instantiated twice, for A and B.

Test Plan:
- a=3, b=4 -> SEND lasts 4 cycles with A=1,1,1,0 and B=1,1,1,1; res_sum=7, res_carry=0; COLLECT lasts 9 cycles.
- a=16, b=16 -> res_sum=15, res_carry=1 (and res_err=0 with the check macro).
- a=0, b=0 -> no SEND cycles, en low through DRAIN; COLLECT lasts 2 cycles; res_sum=0, res_carry=0.
- a=16, b=1 -> res_sum=0, res_carry=1; then an immediate back-to-back a=5, b=0 -> res_sum=5, res_carry=0, with no stale carry.
- Assert rst_n low in the 2nd SEND cycle of a=10, b=10 -> all outputs 0 and in_ready=1 at once; a following a=2, b=2 -> res_sum=4.
- Check macro: force dout low one cycle early during a=6, b=6 COLLECT -> res_sum=11, res_err=1.
